// File: rtl/debounce_lp.sv
// Multi-channel switch debouncer: synchroniser, per-channel polarity, debounce,
// long-press detection and auto-repeat. All outputs are registered in the clk domain.
module debounce_lp #(
    parameter int            DW  = 2,
    parameter int            CW  = 16,
    parameter int            LW  = 24,
    parameter int            SW  = 2,
    parameter logic [DW-1:0] INV = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ena,
    input  logic [CW-1:0] len,
    input  logic [LW-1:0] lng,
    input  logic [LW-1:0] rpt,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] d_o,
    output logic [DW-1:0] d_p,
    output logic [DW-1:0] d_n,
    output logic [DW-1:0] d_l,
    output logic [DW-1:0] d_r
);

    for (genvar gi = 0; gi < DW; gi++) begin : g_ch
        logic [SW-1:0] sync_q, sync_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [LW-1:0] hcnt_q, hcnt_d;
        logic [LW-1:0] rcnt_q, rcnt_d;
        logic          lpd_q, lpd_d;
        logic          out_q, out_d;
        logic          p_q, p_d, n_q, n_d, l_q, l_d, r_q, r_d;
        logic          s;
        logic [LW:0]   hcnt_inc, rcnt_inc;

        assign s        = sync_q[SW-1] ^ INV[gi];
        // One bit wider so the saturated hold count still compares correctly.
        assign hcnt_inc = {1'b0, hcnt_q} + {{LW{1'b0}}, 1'b1};
        assign rcnt_inc = {1'b0, rcnt_q} + {{LW{1'b0}}, 1'b1};

        always_comb begin
            sync_d = {sync_q[SW-2:0], d_i[gi]};
            cnt_d  = cnt_q;
            hcnt_d = hcnt_q;
            rcnt_d = rcnt_q;
            lpd_d  = lpd_q;
            out_d  = out_q;
            p_d    = 1'b0;
            n_d    = 1'b0;
            l_d    = 1'b0;
            r_d    = 1'b0;
            if (!ena) begin
                cnt_d  = '0;
                hcnt_d = '0;
                rcnt_d = '0;
                lpd_d  = 1'b0;
            end else begin
                if (s == out_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= len) begin
                    cnt_d = '0;
                    out_d = s;
                    p_d   = s;
                    n_d   = ~s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end

                // Released, or releasing this cycle: no long/repeat activity.
                if (!out_q || n_d) begin
                    hcnt_d = '0;
                    rcnt_d = '0;
                    lpd_d  = 1'b0;
                end else begin
                    if (hcnt_q != {LW{1'b1}}) begin
                        hcnt_d = hcnt_inc[LW-1:0];
                    end
                    if ((lng != '0) && !lpd_q && (hcnt_inc >= {1'b0, lng})) begin
                        l_d   = 1'b1;
                        lpd_d = 1'b1;
                    end
                    if (lpd_q && (rpt != '0)) begin
                        if (rcnt_inc >= {1'b0, rpt}) begin
                            r_d    = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_inc[LW-1:0];
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q <= {SW{INV[gi]}};
                cnt_q  <= '0;
                hcnt_q <= '0;
                rcnt_q <= '0;
                lpd_q  <= 1'b0;
                out_q  <= 1'b0;
                p_q    <= 1'b0;
                n_q    <= 1'b0;
                l_q    <= 1'b0;
                r_q    <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                hcnt_q <= hcnt_d;
                rcnt_q <= rcnt_d;
                lpd_q  <= lpd_d;
                out_q  <= out_d;
                p_q    <= p_d;
                n_q    <= n_d;
                l_q    <= l_d;
                r_q    <= r_d;
            end
        end

        assign d_o[gi] = out_q;
        assign d_p[gi] = p_q;
        assign d_n[gi] = n_q;
        assign d_l[gi] = l_q;
        assign d_r[gi] = r_q;
    end

endmodule

// File: tb/tb_debounce_lp.sv
// Randomised bench for debounce_lp: a run-length/elapsed-time reference model
// queues expected pulse events, and an independent monitor compares them.
module tb_debounce_lp;
    localparam int         DW  = 2;
    localparam int         CW  = 16;
    localparam int         LW  = 24;
    localparam int         SW  = 2;
    localparam logic [1:0] INV = 2'b10;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          ena  = 1'b0;
    logic [CW-1:0] len  = '0;
    logic [LW-1:0] lng  = '0;
    logic [LW-1:0] rpt  = '0;
    logic [DW-1:0] d_i  = INV;
    logic [DW-1:0] d_o, d_p, d_n, d_l, d_r;

    debounce_lp #(.DW(DW), .CW(CW), .LW(LW), .SW(SW), .INV(INV)) dut (
        .clk(clk), .rstn(rstn), .ena(ena), .len(len), .lng(lng), .rpt(rpt),
        .d_i(d_i), .d_o(d_o), .d_p(d_p), .d_n(d_n), .d_l(d_l), .d_r(d_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] o, p, n, l, r;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_do = 2'b00;

    // Reference model: mismatch run lengths, cycles held since press, and the
    // hold time of the most recent long/repeat pulse.
    logic [1:0] sm [SW];
    int         mm [2];
    int         held [2];
    int         tfire [2];
    bit         fired [2];

    always @(posedge clk or negedge rstn) begin
        logic [1:0] sv, ep, en, el, er;
        logic       old, fall;
        if (!rstn) begin
            for (int k = 0; k < SW; k++) sm[k] = INV;
            for (int c = 0; c < 2; c++) begin
                mm[c] = 0; held[c] = 0; tfire[c] = 0; fired[c] = 0;
            end
            exp_do = 2'b00;
            evq.delete();
        end else begin
            cyc++;
            sv = sm[SW-1] ^ INV;
            for (int k = SW-1; k > 0; k--) sm[k] = sm[k-1];
            sm[0] = d_i;
            ep = 0; en = 0; el = 0; er = 0;
            for (int c = 0; c < 2; c++) begin
                if (!ena) begin
                    mm[c] = 0; held[c] = 0; tfire[c] = 0; fired[c] = 0;
                end else begin
                    old  = exp_do[c];
                    fall = 1'b0;
                    if (sv[c] != exp_do[c]) begin
                        mm[c]++;
                        if (mm[c] >= int'(len) + 1) begin
                            mm[c] = 0;
                            exp_do[c] = sv[c];
                            if (sv[c]) ep[c] = 1'b1;
                            else begin en[c] = 1'b1; fall = 1'b1; end
                        end
                    end else begin
                        mm[c] = 0;
                    end
                    if (!old || fall) begin
                        held[c] = 0; tfire[c] = 0; fired[c] = 0;
                    end else begin
                        held[c]++;
                        if (!fired[c] && lng != 0 && held[c] >= int'(lng)) begin
                            el[c] = 1'b1; fired[c] = 1; tfire[c] = held[c];
                        end else if (fired[c]) begin
                            if (rpt == 0) tfire[c] = held[c];
                            else if (held[c] - tfire[c] >= int'(rpt)) begin
                                er[c] = 1'b1; tfire[c] = held[c];
                            end
                        end
                    end
                end
            end
            if ((ep | en | el | er) != 0)
                evq.push_back('{cyc: cyc, o: exp_do, p: ep, n: en, l: el, r: er});
        end
    end

    // Monitor: level check every cycle, event check whenever either side has one.
    always @(negedge clk) begin
        ev_t e;
        bit  eh;
        n_cmp++;
        if (d_o !== exp_do) begin
            n_bad++;
            $display("FAIL level cyc=%0d d_o=%b required %b", cyc, d_o, exp_do);
        end
        eh = 0;
        e  = '{cyc: cyc, o: exp_do, p: 2'b00, n: 2'b00, l: 2'b00, r: 2'b00};
        if (evq.size() > 0 && evq[0].cyc <= cyc) begin
            e  = evq.pop_front();
            eh = 1;
        end
        if (eh || (d_p | d_n | d_l | d_r) != 0) begin
            n_cmp++;
            if (!eh || e.cyc != cyc || {d_o, d_p, d_n, d_l, d_r} !== {e.o, e.p, e.n, e.l, e.r}) begin
                n_bad++;
                $display("FAIL event cyc=%0d got o=%b p=%b n=%b l=%b r=%b required cyc=%0d o=%b p=%b n=%b l=%b r=%b (expected=%0d)",
                         cyc, d_o, d_p, d_n, d_l, d_r, e.cyc, e.o, e.p, e.n, e.l, e.r, eh);
            end else begin
                $display("event cyc=%0d o=%b p=%b n=%b l=%b r=%b ok", cyc, d_o, d_p, d_n, d_l, d_r);
            end
        end
    end

    // Drive logical levels (polarity applied here) for n cycles, starting on a negedge.
    task automatic run(input int n, input logic [1:0] lv, input logic e);
        for (int i = 0; i < n; i++) begin
            d_i = lv ^ INV;
            ena = e;
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else begin
            $display("check %s = %0h ok", name, got);
        end
    endtask

    initial begin
        int k;
        repeat (4) @(negedge clk);
        check("reset_outputs", {22'd0, d_o, d_p, d_n, d_l, d_r}, 32'd0);
        rstn = 1'b1;
        len = 16'd9; lng = '0; rpt = '0;
        run(5, 2'b00, 1'b1);

        // Latency: SW + len + 1 = 12 edges from the drive to d_o rising.
        d_i = 2'b01 ^ INV;
        for (k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (d_o[0]) break;
        end
        check("latency", k, 12);
        check("ch1_idle", {31'd0, d_o[1]}, 32'd0);
        @(negedge clk);
        run(30, 2'b01, 1'b1);
        run(30, 2'b00, 1'b1);

        // Glitch rejection: pulses never exceed len cycles.
        for (int t = 0; t < 500; ) begin
            int w;
            w = $urandom_range(1, 9);
            run(w, 2'b01, 1'b1);
            run(3, 2'b00, 1'b1);
            t += w + 3;
        end

        // Bouncy presses with long-press and repeat active.
        lng = 24'd300; rpt = 24'd40;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 30; i++) run($urandom_range(1, 9), (i % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
            run(400, 2'b01, 1'b1);
            for (int i = 0; i < 30; i++) run($urandom_range(1, 9), (i % 2 == 0) ? 2'b00 : 2'b01, 1'b1);
            run(400, 2'b00, 1'b1);
        end

        // Long press and repeat.
        len = 16'd4; lng = 24'd100; rpt = 24'd20;
        run(200, 2'b01, 1'b1);
        run(50, 2'b00, 1'b1);

        // Disables.
        lng = '0;
        run(1000, 2'b01, 1'b1);
        run(30, 2'b00, 1'b1);
        lng = 24'd50; rpt = '0;
        run(300, 2'b01, 1'b1);
        run(30, 2'b00, 1'b1);

        // Both channels together, then release together.
        lng = 24'd30; rpt = 24'd7;
        run(80, 2'b11, 1'b1);
        run(30, 2'b00, 1'b1);

        // Enable dropped mid-count, then restart; then dropped during a hold.
        len = 16'd9;
        run(7, 2'b01, 1'b1);
        run(10, 2'b01, 1'b0);
        run(60, 2'b01, 1'b1);
        run(5, 2'b01, 1'b0);
        run(60, 2'b01, 1'b1);
        run(30, 2'b00, 1'b1);

        // Asynchronous reset during a long press.
        len = 16'd4; lng = 24'd100; rpt = 24'd20;
        run(150, 2'b01, 1'b1);
        @(posedge clk);
        #3;
        check("pressed_before_reset", {31'd0, d_o[0]}, 32'd1);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", {22'd0, d_o, d_p, d_n, d_l, d_r}, 32'd0);
        @(negedge clk);
        run(2, 2'b01, 1'b1);
        rstn = 1'b1;
        run(150, 2'b01, 1'b1);
        run(30, 2'b00, 1'b1);

        // Random traffic with parameters changing on the fly.
        for (int i = 0; i < 8000; i++) begin
            logic [1:0] lv;
            if ($urandom_range(0, 199) == 0) begin
                len = CW'($urandom_range(0, 6));
                lng = LW'($urandom_range(0, 40));
                rpt = LW'($urandom_range(0, 10));
            end
            lv = d_i ^ INV;
            if ($urandom_range(0, 29) == 0) lv[0] = ~lv[0];
            if ($urandom_range(0, 29) == 0) lv[1] = ~lv[1];
            run(1, lv, ($urandom_range(0, 39) != 0));
        end

        run(60, 2'b00, 1'b1);
        check("events_drained", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
